// File: rtl/fpadder_arbiter.sv
// Shares one pipelined fpadder among NUM_REQ requesters: round-robin issue, ID shadow pipe, result FIFO.
// Grant to rsp_valid is LATENCY+1 cycles; credits stop issue so a stalled rsp_ready never drops a result.
module fpadder_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    input  logic [NUM_REQ-1:0]     req_as,
    output logic [31:0]            fpa_a,
    output logic [31:0]            fpa_b,
    output logic                   fpa_as,
    input  logic [31:0]            fpa_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [31:0]            rsp_data,
    output logic                   busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + LATENCY + 1);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
    } rsp_t;

    logic [ID_W-1:0]  rr_q, rr_d;
    logic [LATENCY-1:0] sh_vld_q;
    logic [ID_W-1:0]  sh_id_q [LATENCY];
    rsp_t             mem_q [FIFO_DEPTH];
    rsp_t             head;
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, inflight;
    logic             credit_ok, gnt_vld, push, pop;
    logic [ID_W-1:0]  gnt_id;
    int               idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + CNT_W'(sh_vld_q[i]);
        end
    end

    // A pop this cycle is not counted until cnt_q updates, so credit lags by one cycle.
    assign credit_ok = reset && ((cnt_q + inflight) < CNT_W'(FIFO_DEPTH));

    // Descending scan so the lowest offset from rr_q is the last (winning) assignment.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        if (credit_ok) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = (int'(rr_q) + k) % NUM_REQ;
                if (req_valid[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = ID_W'(idx);
                end
            end
        end
    end

    assign rr_d      = gnt_vld ? ID_W'((int'(gnt_id) + 1) % NUM_REQ) : rr_q;
    assign req_ready = gnt_vld ? (NUM_REQ'(1) << gnt_id) : '0;
    assign fpa_a     = gnt_vld ? req_a[32*gnt_id +: 32] : '0;
    assign fpa_b     = gnt_vld ? req_b[32*gnt_id +: 32] : '0;
    assign fpa_as    = gnt_vld & req_as[gnt_id];

    assign push      = sh_vld_q[LATENCY-1];
    assign rsp_valid = (cnt_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign head      = mem_q[rd_q];
    assign rsp_id    = rsp_valid ? head.id : '0;
    assign rsp_data  = rsp_valid ? head.data : '0;
    assign busy      = (inflight != '0) | rsp_valid;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_q     <= '0;
            sh_vld_q <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
        end else begin
            rr_q        <= rr_d;
            sh_vld_q[0] <= gnt_vld;
            for (int i = 1; i < LATENCY; i++) begin
                sh_vld_q[i] <= sh_vld_q[i-1];
            end
            if (push) wr_q <= ptr_inc(wr_q);
            if (pop)  rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_d;
        end
    end

    // Datapath storage needs no reset; validity is carried by sh_vld_q and cnt_q.
    always_ff @(posedge clk) begin
        sh_id_q[0] <= gnt_id;
        for (int i = 1; i < LATENCY; i++) begin
            sh_id_q[i] <= sh_id_q[i-1];
        end
        if (reset && push) begin
            mem_q[wr_q] <= '{id: sh_id_q[LATENCY-1], data: fpa_result};
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
        !(push && cnt_q == CNT_W'(FIFO_DEPTH)));

endmodule
